// File: rtl/if_id_buf.sv
// Two-entry skid buffer between fetch and decode; registered in_ready, flushable by execute redirects.
// Optional performance counters (stall_cnt, flush_cnt) are built when IFID_PERF_CNT_EN is defined.
module if_id_buf #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_pc_nxt,
    input  logic [XLEN-1:0]  in_instr,
    output logic             in_ready,
    input  logic             flush,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  id_pc_nxt,
    output logic [XLEN-1:0]  id_instr,
    input  logic             id_ready
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_nxt;
        logic [XLEN-1:0] instr;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   in_ready_q, in_ready_d;
    logic   id_valid_q, id_valid_d;
    logic   push, pop;

    assign in_entry = '{pc: in_pc, pc_nxt: in_pc_nxt, instr: in_instr};
    assign push     = in_valid & in_ready_q;
    assign pop      = id_valid_q & id_ready;

    // Next-state and storage steering; flush overrides any push or pop
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_d  = in_entry;
                        state_d = HALF;
                    end
                end
                HALF: begin
                    if (push && pop) begin
                        head_d = in_entry;
                    end else if (push) begin
                        skid_d  = in_entry;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_d  = skid_q;
                        state_d = HALF;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != FULL);
        id_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign id_valid  = id_valid_q;
    assign id_pc     = head_q.pc;
    assign id_pc_nxt = head_q.pc_nxt;
    assign id_instr  = head_q.instr;

`ifdef IFID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (id_valid_q && !id_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_buf.sv
// Self-checking bench for if_id_buf: directed vector table, async-reset and counter sequences, random vs queue model.
module tb_if_id_buf;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_pc_nxt;
    logic [XLEN-1:0] in_instr;
    logic            in_ready;
    logic            flush;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc_nxt;
    logic [XLEN-1:0] id_instr;
    logic            id_ready;
`ifdef IFID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    if_id_buf #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_pc_nxt (in_pc_nxt),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_pc     (id_pc),
        .id_pc_nxt (id_pc_nxt),
        .id_instr  (id_instr),
        .id_ready  (id_ready)
`ifdef IFID_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3*XLEN-1:0] data;
    } mentry_t;

    mentry_t mq[$];
    logic    m_in_ready;

    typedef struct {
        logic            v_in_valid;
        logic [XLEN-1:0] v_pc;
        logic            v_flush;
        logic            v_id_ready;
        logic            e_valid;
        logic [XLEN-1:0] e_pc;
        logic            e_in_ready;
    } vec_t;

    vec_t vt[19];

    function automatic logic [XLEN-1:0] instr_of(input logic [XLEN-1:0] pc);
        if (pc == 32'd1) return 32'h0015_8593;
        return 32'hA500_0000 ^ (pc * 32'd7);
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_in_ready = 1'b1;
    endtask

    // FIFO of at most two entries; one edge of the handshake rules
    task automatic model_edge();
        bit      do_push, do_pop;
        mentry_t e;
        do_push = in_valid && m_in_ready;
        do_pop  = (mq.size() > 0) && id_ready;
        e.data  = {in_pc, in_pc_nxt, in_instr};
        if (flush) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
        m_in_ready = (mq.size() < 2);
    endtask

    task automatic model_check(input string tag);
        chk({tag, "_id_valid"}, 32'(id_valid), 32'(mq.size() > 0));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(m_in_ready));
        if (mq.size() > 0) begin
            chk({tag, "_id_pc"},     id_pc,     mq[0].data[3*XLEN-1:2*XLEN]);
            chk({tag, "_id_pc_nxt"}, id_pc_nxt, mq[0].data[2*XLEN-1:XLEN]);
            chk({tag, "_id_instr"},  id_instr,  mq[0].data[XLEN-1:0]);
        end
    endtask

    task automatic step(input logic v, input logic [XLEN-1:0] pc, input logic fl, input logic rdy);
        in_valid  = v;
        in_pc     = pc;
        in_pc_nxt = pc + 32'd1;
        in_instr  = instr_of(pc);
        flush     = fl;
        id_ready  = rdy;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_pc = '0; in_pc_nxt = '0; in_instr = '0;
        flush = 1'b0; id_ready = 1'b0;
        model_reset();

        // Stream, decode stall, flush while FULL, simultaneous push/pop in HALF
        vt[0]  = '{1'b1, 32'd0,  1'b0, 1'b1, 1'b1, 32'd0,  1'b1};
        vt[1]  = '{1'b1, 32'd1,  1'b0, 1'b1, 1'b1, 32'd1,  1'b1};
        vt[2]  = '{1'b1, 32'd2,  1'b0, 1'b1, 1'b1, 32'd2,  1'b1};
        vt[3]  = '{1'b1, 32'd3,  1'b0, 1'b1, 1'b1, 32'd3,  1'b1};
        vt[4]  = '{1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd0,  1'b1};
        vt[5]  = '{1'b1, 32'd4,  1'b0, 1'b1, 1'b1, 32'd4,  1'b1};
        vt[6]  = '{1'b1, 32'd5,  1'b0, 1'b0, 1'b1, 32'd4,  1'b0};
        vt[7]  = '{1'b1, 32'd6,  1'b0, 1'b0, 1'b1, 32'd4,  1'b0};
        vt[8]  = '{1'b1, 32'd6,  1'b0, 1'b1, 1'b1, 32'd5,  1'b1};
        vt[9]  = '{1'b1, 32'd6,  1'b0, 1'b1, 1'b1, 32'd6,  1'b1};
        vt[10] = '{1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd0,  1'b1};
        vt[11] = '{1'b1, 32'd8,  1'b0, 1'b0, 1'b1, 32'd8,  1'b1};
        vt[12] = '{1'b1, 32'd9,  1'b0, 1'b0, 1'b1, 32'd8,  1'b0};
        vt[13] = '{1'b1, 32'd10, 1'b1, 1'b0, 1'b0, 32'd0,  1'b1};
        vt[14] = '{1'b1, 32'd20, 1'b0, 1'b0, 1'b1, 32'd20, 1'b1};
        vt[15] = '{1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd0,  1'b1};
        vt[16] = '{1'b1, 32'd3,  1'b0, 1'b0, 1'b1, 32'd3,  1'b1};
        vt[17] = '{1'b1, 32'd4,  1'b0, 1'b1, 1'b1, 32'd4,  1'b1};
        vt[18] = '{1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd0,  1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_id_valid",  32'(id_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_id_pc",     id_pc,     32'd0);
        chk("rst_id_pc_nxt", id_pc_nxt, 32'd0);
        chk("rst_id_instr",  id_instr,  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            step(vt[i].v_in_valid, vt[i].v_pc, vt[i].v_flush, vt[i].v_id_ready);
            chk($sformatf("vec%0d_id_valid", i), 32'(id_valid), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_in_ready));
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d_id_pc", i),     id_pc,     vt[i].e_pc);
                chk($sformatf("vec%0d_id_pc_nxt", i), id_pc_nxt, vt[i].e_pc + 32'd1);
                chk($sformatf("vec%0d_id_instr", i),  id_instr,  instr_of(vt[i].e_pc));
            end
            model_check($sformatf("vec%0d_model", i));
        end

        // Async reset while FULL takes effect without a clock edge
        step(1'b1, 32'd40, 1'b0, 1'b0);
        step(1'b1, 32'd41, 1'b0, 1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_id_valid", 32'(id_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        model_reset();
        in_valid = 1'b0; flush = 1'b0; id_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef IFID_PERF_CNT_EN
        chk("cnt_rst_stall", 32'(stall_cnt), 32'd0);
        chk("cnt_rst_flush", 32'(flush_cnt), 32'd0);
        step(1'b1, 32'd100, 1'b0, 1'b0);
        repeat (5) step(1'b0, 32'd0, 1'b0, 1'b0);
        chk("cnt_stall5", 32'(stall_cnt), 32'd5);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        chk("cnt_stall_after_flush", 32'(stall_cnt), 32'd5);
        chk("cnt_flush2", 32'(flush_cnt), 32'd2);
        step(1'b1, 32'd200, 1'b0, 1'b0);
        for (int i = 0; i < (1 << CNT_W) + 3; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
        chk("cnt_stall_sat", 32'(stall_cnt), 32'h0000_FFFF);
        chk("cnt_sat_id_pc", id_pc, 32'd200);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        chk("cnt_flush3", 32'(flush_cnt), 32'd3);
`endif

        // Random traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 32'($urandom),
                 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 6));
            model_check($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_buf.md
Name: if_id_buf

Overview:
Decoupling buffer between the fetch stage and the decode stage of the rv32 pipeline. Captures each fetched {pc, pc_nxt, instr} triple and presents it to decode through a valid/ready handshake. The buffer is a 2-entry skid buffer, so fetch sees a registered stall signal and no in-flight fetch is lost. Branch/jump redirects from execute flush it.

Parameters:
XLEN, 32, width of pc, pc_nxt and instruction fields
CNT_W, 16, width of optional performance counters

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  fetch presents a valid triple this cycle
in_pc  input  XLEN  word-addressed PC of fetched instruction
in_pc_nxt  input  XLEN  in_pc + 1 (word addressing)
in_instr  input  XLEN  fetched instruction word
in_ready  output  1  buffer can accept; registered; fetch must hold PC when low
flush  input  1  redirect from execute; discard all buffered and incoming entries
id_valid  output  1  head entry valid for decode
id_pc  output  XLEN  head entry PC
id_pc_nxt  output  XLEN  head entry next PC
id_instr  output  XLEN  head entry instruction
id_ready  input  1  decode consumes head this cycle (low = hazard stall)
stall_cnt  output  CNT_W  only with IFID_PERF_CNT_EN
flush_cnt  output  CNT_W  only with IFID_PERF_CNT_EN

Behaviour:
- Reset (rst_n low, async): state EMPTY; in_ready=1; id_valid=0; id_pc, id_pc_nxt, id_instr = 0; counters 0. Deassertion is taken synchronously at the next clk edge.
- push = in_valid & in_ready; pop = id_valid & id_ready.
- Storage: head register (drives id_* directly, no comb path from in_*) and skid register.
- FSM states: EMPTY (0 entries), HALF (head only), FULL (head + skid).
  - EMPTY: push -> HALF, head <= in_*.
  - HALF: push & pop -> HALF, head <= in_*. push only -> FULL, skid <= in_*. pop only -> EMPTY.
  - FULL: pop -> HALF, head <= skid. No push is possible because in_ready=0.
- id_valid = (state != EMPTY). in_ready = (state != FULL), registered from next state.
- Latency: 1 cycle from push to id_valid when EMPTY. Throughput is 1/cycle with id_ready held high.
- Ordering is strict FIFO. The skid entry always precedes any later push.
- flush has priority over push/pop. Next state is EMPTY and in_ready=1. Any push in the flush cycle is discarded. id_valid is 0 the cycle after a flush. Data registers need not clear; id_* are don't-care while id_valid=0.
- Outputs are stable while id_valid=1 and id_ready=0.
- Reset mid-operation drops all entries immediately.
- in_pc_nxt is passed through unmodified; no arithmetic is done in this block.

Optional Feature:
Macro IFID_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with id_valid=1 and id_ready=0.
  - flush_cnt increments each cycle flush=1.
  - Both are CNT_W bits, saturate at all-ones, and reset to 0.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then stream: rst_n 0->1, in_valid=1 with pc 0..3 (pc_nxt 1..4), instr 0x00158593 at pc 1, id_ready=1 -> id_valid rises 1 cycle after the first push; id_pc sequence 0,1,2,3 on consecutive cycles; id_instr=0x00158593 when id_pc=1; in_ready stays 1.
- Decode stall: stream pc 4,5,6, id_ready=0 from the 2nd cycle -> state FULL, in_ready=0, id_pc holds 4 with the same instr. id_ready=1 -> outputs pc 5 then 6, no loss or duplication.
- Flush while FULL: pc 8,9 buffered, flush=1 with in_valid=1 pc 10 -> next cycle id_valid=0, in_ready=1. Pc 10 is never presented; the next push, pc 20, appears as id_pc=20.
- Simultaneous push/pop in HALF: head pc 3, push pc 4, id_ready=1 -> next cycle id_pc=4, state HALF, in_ready=1.
- Async reset mid-stream: rst_n low mid-cycle while FULL -> id_valid=0 and in_ready=1 immediately, without waiting for clk.
- With IFID_PERF_CNT_EN: 5 stall cycles plus 2 flush pulses -> stall_cnt=5, flush_cnt=2. Forcing 2^CNT_W+3 stall cycles -> stall_cnt=0xFFFF.
